fetch_pc_ctrl: RTL and testbench



---
 rtl/fetch_pc_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: one outstanding I-mem request, IR toward decode,
// static next-PC prediction from the mini-decoder, jalr rs1 interlock and flush.
module fetch_pc_ctrl #(
  parameter int unsigned     XLEN          = 32,
  parameter int unsigned     REG_IDX_WIDTH = 5,
  parameter logic [XLEN-1:0] RESET_PC      = XLEN'(32'h8000_0000)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     ifu_req_valid_o,
  input  logic                     ifu_req_ready_i,
  output logic [XLEN-1:0]          ifu_req_pc_o,
  input  logic                     ifu_rsp_valid_i,
  input  logic [31:0]              ifu_rsp_instr_i,
  output logic [31:0]              dec_instr_o,
  input  logic                     dec_bxx_i,
  input  logic                     dec_jal_i,
  input  logic                     dec_jalr_i,
  input  logic [REG_IDX_WIDTH-1:0] dec_jalr_rs1_idx_i,
  input  logic [XLEN-1:0]          dec_bjp_imm_i,
  output logic [REG_IDX_WIDTH-1:0] rs1_idx_o,
  input  logic [XLEN-1:0]          rs1_rdata_i,
  input  logic                     rs1_busy_i,
  output logic                     ir_valid_o,
  input  logic                     ir_ready_i,
  output logic [31:0]              ir_instr_o,
  output logic [XLEN-1:0]          ir_pc_o,
  output logic                     ir_pred_taken_o,
  input  logic                     flush_i,
  input  logic [XLEN-1:0]          flush_pc_i
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REQ       = 3'd1;
  localparam logic [2:0] S_WAIT_RSP  = 3'd2;
  localparam logic [2:0] S_JALR_WAIT = 3'd3;
  localparam logic [2:0] S_HOLD      = 3'd4;
  localparam logic [2:0] S_DRAIN     = 3'd5;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [2:0]               state_q, state_d;
  logic [XLEN-1:0]          pc_q, pc_d;
  logic [XLEN-1:0]          imm_q, imm_d;
  logic [REG_IDX_WIDTH-1:0] rs1_idx_q, rs1_idx_d;
  logic                     req_valid_q, req_valid_d;
  logic                     ir_valid_q, ir_valid_d;
  logic [31:0]              ir_instr_q, ir_instr_d;
  logic [XLEN-1:0]          ir_pc_q, ir_pc_d;
  logic                     ir_pred_q, ir_pred_d;
  logic [XLEN-1:0]          jalr_rsp_sum;
  logic [XLEN-1:0]          jalr_wait_sum;

  function automatic logic [XLEN-1:0] clr_lsb(input logic [XLEN-1:0] a);
    return {a[XLEN-1:1], 1'b0};
  endfunction

  assign dec_instr_o     = ifu_rsp_instr_i;
  // In the response cycle the regfile is read with the decoder's index so jalr can resolve at once.
  assign rs1_idx_o       = (state_q == S_WAIT_RSP) ? dec_jalr_rs1_idx_i : rs1_idx_q;
  assign ifu_req_valid_o = req_valid_q;
  assign ifu_req_pc_o    = pc_q;
  assign ir_valid_o      = ir_valid_q;
  assign ir_instr_o      = ir_instr_q;
  assign ir_pc_o         = ir_pc_q;
  assign ir_pred_taken_o = ir_pred_q;

  assign jalr_rsp_sum  = rs1_rdata_i + dec_bjp_imm_i;
  assign jalr_wait_sum = rs1_rdata_i + imm_q;

  // Next-state, next-PC and IR load logic; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    rs1_idx_d  = rs1_idx_q;
    ir_valid_d = ir_valid_q & ~ir_ready_i;
    ir_instr_d = ir_instr_q;
    ir_pc_d    = ir_pc_q;
    ir_pred_d  = ir_pred_q;
    if (flush_i) begin
      pc_d       = flush_pc_i;
      ir_valid_d = 1'b0;
      case (state_q)
        S_REQ:      state_d = ifu_req_ready_i ? S_DRAIN : S_REQ;
        S_WAIT_RSP: state_d = ifu_rsp_valid_i ? S_REQ : S_DRAIN;
        S_DRAIN:    state_d = S_DRAIN;
        default:    state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (ifu_req_ready_i) state_d = S_WAIT_RSP;
        end
        S_WAIT_RSP: begin
          if (ifu_rsp_valid_i) begin
            ir_valid_d = 1'b1;
            ir_instr_d = ifu_rsp_instr_i;
            ir_pc_d    = pc_q;
            ir_pred_d  = (dec_bxx_i & dec_bjp_imm_i[XLEN-1]) | dec_jal_i | dec_jalr_i;
            imm_d      = dec_bjp_imm_i;
            rs1_idx_d  = dec_jalr_rs1_idx_i;
            state_d    = S_HOLD;
            if (dec_bxx_i) begin
              pc_d = dec_bjp_imm_i[XLEN-1] ? pc_q + dec_bjp_imm_i : pc_q + PC_STEP;
            end else if (dec_jal_i) begin
              pc_d = pc_q + dec_bjp_imm_i;
            end else if (dec_jalr_i) begin
              if (dec_jalr_rs1_idx_i == '0) begin
                pc_d = clr_lsb(dec_bjp_imm_i);
              end else if (!rs1_busy_i) begin
                pc_d = clr_lsb(jalr_rsp_sum);
              end else begin
                state_d = S_JALR_WAIT;
              end
            end else begin
              pc_d = pc_q + PC_STEP;
            end
          end
        end
        S_JALR_WAIT: begin
          if (!rs1_busy_i) begin
            pc_d    = clr_lsb(jalr_wait_sum);
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!ir_valid_q || ir_ready_i) state_d = S_REQ;
        end
        S_DRAIN: begin
          if (ifu_rsp_valid_i) state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end
    req_valid_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      imm_q       <= '0;
      rs1_idx_q   <= '0;
      req_valid_q <= 1'b0;
      ir_valid_q  <= 1'b0;
      ir_instr_q  <= '0;
      ir_pc_q     <= '0;
      ir_pred_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      rs1_idx_q   <= rs1_idx_d;
      req_valid_q <= req_valid_d;
      ir_valid_q  <= ir_valid_d;
      ir_instr_q  <= ir_instr_d;
      ir_pc_q     <= ir_pc_d;
      ir_pred_q   <= ir_pred_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios plus a randomized run checked
// against a program-level next-PC / IR-stream reference model.
module tb_fetch_pc_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RIW  = 5;
  localparam logic [31:0] RPC  = 32'h8000_0000;
  localparam logic [31:0] PLAIN = 32'h0000_2A00;

  logic            clk, rst_i;
  logic            ifu_req_valid_o, ifu_req_ready_i;
  logic [31:0]     ifu_req_pc_o;
  logic            ifu_rsp_valid_i;
  logic [31:0]     ifu_rsp_instr_i, dec_instr_o;
  logic            dec_bxx_i, dec_jal_i, dec_jalr_i;
  logic [RIW-1:0]  dec_jalr_rs1_idx_i, rs1_idx_o;
  logic [31:0]     dec_bjp_imm_i, rs1_rdata_i;
  logic            rs1_busy_i;
  logic            ir_valid_o, ir_ready_i, ir_pred_taken_o;
  logic [31:0]     ir_instr_o, ir_pc_o;
  logic            flush_i;
  logic [31:0]     flush_pc_i;

  fetch_pc_ctrl #(.XLEN(XLEN), .REG_IDX_WIDTH(RIW), .RESET_PC(RPC)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ifu_req_valid_o(ifu_req_valid_o), .ifu_req_ready_i(ifu_req_ready_i),
    .ifu_req_pc_o(ifu_req_pc_o), .ifu_rsp_valid_i(ifu_rsp_valid_i),
    .ifu_rsp_instr_i(ifu_rsp_instr_i), .dec_instr_o(dec_instr_o),
    .dec_bxx_i(dec_bxx_i), .dec_jal_i(dec_jal_i), .dec_jalr_i(dec_jalr_i),
    .dec_jalr_rs1_idx_i(dec_jalr_rs1_idx_i), .dec_bjp_imm_i(dec_bjp_imm_i),
    .rs1_idx_o(rs1_idx_o), .rs1_rdata_i(rs1_rdata_i), .rs1_busy_i(rs1_busy_i),
    .ir_valid_o(ir_valid_o), .ir_ready_i(ir_ready_i), .ir_instr_o(ir_instr_o),
    .ir_pc_o(ir_pc_o), .ir_pred_taken_o(ir_pred_taken_o),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench instruction encoding: [1:0] class (0 other, 1 bxx, 2 jal, 3 jalr), [6:2] rs1, [31:7] imm.
  assign dec_bxx_i          = (dec_instr_o[1:0] == 2'd1);
  assign dec_jal_i          = (dec_instr_o[1:0] == 2'd2);
  assign dec_jalr_i         = (dec_instr_o[1:0] == 2'd3);
  assign dec_jalr_rs1_idx_i = dec_instr_o[6:2];
  assign dec_bjp_imm_i      = {{7{dec_instr_o[31]}}, dec_instr_o[31:7]};

  logic [31:0] rf [0:31];
  assign rs1_rdata_i = rf[rs1_idx_o];

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  bit          rand_prog = 0;
  int          mem_lat = 0;
  bit          outstanding = 0;
  int          cnt = 0;
  logic [31:0] out_pc;

  bit          hs_ev, dh_ev, rsp_ev, dbl_ev, fl_ev;
  logic [31:0] hs_pc, dh_instr, dh_pc;
  logic        dh_pred;
  logic [31:0] last_dh_pc;
  logic        last_dh_pred;
  int          cyc = 0;

  function automatic logic [31:0] mk(input logic [1:0] cls, input logic [4:0] rs, input logic [31:0] imm);
    return {imm[24:0], rs, cls};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] off;
    off = 32'($urandom_range(0, 32)) * 32'd4 - 32'd64;
    case ($urandom_range(0, 3))
      0:       return mk(2'd0, 5'($urandom), 32'($urandom));
      1:       return mk(2'd1, 5'd0, off);
      2:       return mk(2'd2, 5'd0, off);
      default: return mk(2'd3, 5'($urandom_range(0, 7)), 32'($urandom_range(0, 15)));
    endcase
  endfunction

  // One clock: log handshakes seen at the edge and play the memory side.
  task automatic step();
    logic hs, dh, rv, dpr, fl;
    logic [31:0] hp, di, dp;
    hs = ifu_req_valid_o & ifu_req_ready_i; hp = ifu_req_pc_o;
    dh = ir_valid_o & ir_ready_i; di = ir_instr_o; dp = ir_pc_o; dpr = ir_pred_taken_o;
    rv = ifu_rsp_valid_i; fl = flush_i;
    @(posedge clk); #1;
    cyc++;
    hs_ev = hs; hs_pc = hp; dh_ev = dh; dh_instr = di; dh_pc = dp; dh_pred = dpr;
    rsp_ev = rv; fl_ev = fl; dbl_ev = 0;
    if (dh) begin last_dh_pc = dp; last_dh_pred = dpr; end
    if (rv) outstanding = 0;
    if (hs) begin
      dbl_ev = outstanding;
      outstanding = 1; out_pc = hp; cnt = mem_lat;
      if (!mem.exists(hp)) mem[hp] = rand_prog ? rand_instr() : PLAIN;
    end
    if (outstanding && cnt == 0) begin
      ifu_rsp_valid_i = 1'b1; ifu_rsp_instr_i = mem[out_pc];
    end else begin
      ifu_rsp_valid_i = 1'b0; ifu_rsp_instr_i = $urandom;
      if (outstanding) cnt--;
    end
  endtask

  task automatic run_until_req(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      step();
      if (hs_ev) ok = 1;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; flush_i = 1'b0; ifu_rsp_valid_i = 1'b0; outstanding = 0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; ifu_req_ready_i = 1'b1; ifu_rsp_valid_i = 1'b0; ifu_rsp_instr_i = '0;
    rs1_busy_i = 1'b0; ir_ready_i = 1'b1; flush_i = 1'b0; flush_pc_i = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ifu_req_valid_o !== 1'b0 || ir_valid_o !== 1'b0 || ir_instr_o !== 32'h0 || ir_pc_o !== 32'h0 ||
        ir_pred_taken_o !== 1'b0 || rs1_idx_o !== 5'd0 || ifu_req_pc_o !== RPC) begin
      errors++;
      $display("FAIL reset_values: req_valid=%b ir_valid=%b instr=%h ir_pc=%h pred=%b rs1=%0d pc=%h, required 0 0 0 0 0 0 %h",
               ifu_req_valid_o, ir_valid_o, ir_instr_o, ir_pc_o, ir_pred_taken_o, rs1_idx_o, ifu_req_pc_o, RPC);
    end
    rst_i = 1'b0;
    step();
    checks++;
    if (ifu_req_valid_o !== 1'b1 || ifu_req_pc_o !== RPC) begin
      errors++;
      $display("FAIL first_request: valid=%b pc=%h, required 1 %h", ifu_req_valid_o, ifu_req_pc_o, RPC);
    end
  endtask

  task automatic test_sequential();
    bit ok; int c0;
    run_until_req(10, ok);
    checks++;
    if (!ok || hs_pc !== RPC) begin
      errors++; $display("FAIL seq_req0: ok=%0d pc=%h, required 1 %h", ok, hs_pc, RPC);
    end
    c0 = cyc;
    run_until_req(10, ok);
    checks++;
    if (!ok || hs_pc !== RPC + 32'd4 || cyc - c0 != 3) begin
      errors++; $display("FAIL seq_req1: ok=%0d pc=%h gap=%0d, required 1 %h 3", ok, hs_pc, cyc - c0, RPC + 32'd4);
    end
    checks++;
    if (last_dh_pc !== RPC || last_dh_pred !== 1'b0) begin
      errors++; $display("FAIL seq_ir: pc=%h pred=%b, required %h 0", last_dh_pc, last_dh_pred, RPC);
    end
  endtask

  task automatic test_branch();
    bit ok;
    logic [31:0] bpc, tgt[2];
    logic        prd[2];
    bpc = RPC + 32'h10;
    tgt[0] = RPC;          prd[0] = 1'b1;
    tgt[1] = RPC + 32'h14; prd[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem[bpc] = mk(2'd1, 5'd0, (k == 0) ? 32'hFFFF_FFF0 : 32'd8);
      ok = 0;
      for (int i = 0; i < 8 && !(ok && hs_pc === bpc); i++) run_until_req(10, ok);
      run_until_req(10, ok);
      checks++;
      if (!ok || hs_pc !== tgt[k] || last_dh_pc !== bpc || last_dh_pred !== prd[k]) begin
        errors++;
        $display("FAIL branch_%0d: next=%h ir_pc=%h pred=%b, required %h %h %b",
                 k, hs_pc, last_dh_pc, last_dh_pred, tgt[k], bpc, prd[k]);
      end
    end
  endtask

  task automatic test_jalr();
    bit ok;
    mem[RPC] = mk(2'd3, 5'd5, 32'd3);
    rf[5] = 32'h100;
    rs1_busy_i = 1'b1;
    do_reset();
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin step(); ok = rsp_ev; end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (!ok || hs_ev || ifu_req_valid_o !== 1'b0 || rs1_idx_o !== 5'd5) begin
        errors++;
        $display("FAIL jalr_wait_%0d: rsp_seen=%0d req=%b rs1=%0d, required 1 0 5", i, ok, ifu_req_valid_o, rs1_idx_o);
      end
      step();
    end
    rs1_busy_i = 1'b0;
    run_until_req(10, ok);
    checks++;
    if (!ok || hs_pc !== 32'h102 || last_dh_pred !== 1'b1) begin
      errors++; $display("FAIL jalr_target: pc=%h pred=%b, required 00000102 1", hs_pc, last_dh_pred);
    end
  endtask

  task automatic test_stall();
    bit ok;
    mem[RPC] = PLAIN;
    ir_ready_i = 1'b0;
    do_reset();
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin step(); ok = rsp_ev; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (!ok || ir_valid_o !== 1'b1 || ir_instr_o !== PLAIN || ir_pc_o !== RPC ||
          ir_pred_taken_o !== 1'b0 || ifu_req_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d: v=%b instr=%h pc=%h pred=%b req=%b, required 1 %h %h 0 0",
                 i, ir_valid_o, ir_instr_o, ir_pc_o, ir_pred_taken_o, ifu_req_valid_o, PLAIN, RPC);
      end
      step();
    end
    ir_ready_i = 1'b1;
    step();
    checks++;
    if (!dh_ev || ifu_req_valid_o !== 1'b1 || ifu_req_pc_o !== RPC + 32'd4) begin
      errors++;
      $display("FAIL stall_release: consumed=%0d req=%b pc=%h, required 1 1 %h", dh_ev, ifu_req_valid_o, ifu_req_pc_o, RPC + 32'd4);
    end
  endtask

  task automatic test_flush();
    bit ok, saw_rsp, ir_bad;
    mem[RPC] = PLAIN;
    mem_lat = 2;
    do_reset();
    run_until_req(10, ok);
    flush_i = 1'b1; flush_pc_i = 32'h200;
    step();
    flush_i = 1'b0; mem_lat = 0;
    saw_rsp = 0; ir_bad = 0; ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step();
      if (rsp_ev) saw_rsp = 1;
      if (ir_valid_o !== 1'b0) ir_bad = 1;
      ok = hs_ev;
    end
    checks++;
    if (!ok || !saw_rsp || ir_bad || hs_pc !== 32'h200) begin
      errors++;
      $display("FAIL flush_wait: req=%0d rsp=%0d ir_valid_seen=%0d pc=%h, required 1 1 0 00000200", ok, saw_rsp, ir_bad, hs_pc);
    end
    flush_i = 1'b1; flush_pc_i = 32'h200;
    step();
    flush_i = 1'b0;
    checks++;
    if (!rsp_ev || ifu_req_valid_o !== 1'b1 || ifu_req_pc_o !== 32'h200 || ir_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_rsp: rsp=%0d req=%b pc=%h ir_valid=%b, required 1 1 00000200 0",
               rsp_ev, ifu_req_valid_o, ifu_req_pc_o, ir_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    mem[RPC] = mk(2'd3, 5'd5, 32'd0);
    rs1_busy_i = 1'b1;
    do_reset();
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin step(); ok = rsp_ev; end
    step();
    rst_i = 1'b1; ifu_rsp_valid_i = 1'b0; outstanding = 0;
    #1;
    checks++;
    if (!ok || ifu_req_valid_o !== 1'b0 || ir_valid_o !== 1'b0 || ir_instr_o !== 32'h0 || ir_pc_o !== 32'h0 ||
        ir_pred_taken_o !== 1'b0 || rs1_idx_o !== 5'd0 || ifu_req_pc_o !== RPC) begin
      errors++;
      $display("FAIL reset_mid: req=%b ir_valid=%b instr=%h ir_pc=%h pred=%b rs1=%0d pc=%h, required 0 0 0 0 0 0 %h",
               ifu_req_valid_o, ir_valid_o, ir_instr_o, ir_pc_o, ir_pred_taken_o, rs1_idx_o, ifu_req_pc_o, RPC);
    end
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    rs1_busy_i = 1'b0; mem[RPC] = PLAIN;
    run_until_req(10, ok);
    checks++;
    if (!ok || hs_pc !== RPC) begin
      errors++; $display("FAIL reset_mid_restart: ok=%0d pc=%h, required 1 %h", ok, hs_pc, RPC);
    end
  endtask

  // Program-level model: each accepted, un-flushed response yields one IR entry and the next fetch PC.
  task automatic test_random();
    logic [31:0] exp_pc, ins, imm, nxt;
    logic [31:0] q_instr[$], q_pc[$];
    logic        q_pred[$];
    logic        prd;
    bit          live;
    int          n_req, n_ir;
    mem.delete();
    rand_prog = 1;
    rf[0] = 32'h0;
    for (int i = 1; i < 32; i++) rf[i] = RPC + 32'h100 + 32'(i) * 32'h20;
    rs1_busy_i = 1'b0; ir_ready_i = 1'b1; ifu_req_ready_i = 1'b1;
    do_reset();
    exp_pc = RPC; live = 0; n_req = 0; n_ir = 0;
    for (int c = 0; c < 4000; c++) begin
      ifu_req_ready_i = ($urandom_range(0, 3) != 0);
      ir_ready_i      = ($urandom_range(0, 2) != 0);
      rs1_busy_i      = ($urandom_range(0, 2) == 0);
      mem_lat         = $urandom_range(0, 2);
      flush_i         = ($urandom_range(0, 19) == 0);
      flush_pc_i      = RPC + 32'($urandom_range(0, 63)) * 32'd4;
      step();
      checks++;
      if (dbl_ev || dec_instr_o !== ifu_rsp_instr_i) begin
        errors++;
        $display("FAIL rand_bus c=%0d: second_outstanding=%0d dec_instr=%h, required 0 %h", c, dbl_ev, dec_instr_o, ifu_rsp_instr_i);
      end
      if (dh_ev) begin
        checks++; n_ir++;
        if (q_pc.size() == 0) begin
          errors++; $display("FAIL rand_ir c=%0d: unexpected IR pc=%h instr=%h", c, dh_pc, dh_instr);
        end else begin
          if (dh_instr !== q_instr[0] || dh_pc !== q_pc[0] || dh_pred !== q_pred[0]) begin
            errors++;
            $display("FAIL rand_ir c=%0d: instr=%h pc=%h pred=%b, required %h %h %b",
                     c, dh_instr, dh_pc, dh_pred, q_instr[0], q_pc[0], q_pred[0]);
          end
          void'(q_instr.pop_front()); void'(q_pc.pop_front()); void'(q_pred.pop_front());
        end
      end
      if (rsp_ev) begin
        if (live && !fl_ev) begin
          ins = mem[out_pc];
          imm = {{7{ins[31]}}, ins[31:7]};
          case (ins[1:0])
            2'd1: begin prd = imm[31]; nxt = prd ? exp_pc + imm : exp_pc + 32'd4; end
            2'd2: begin prd = 1'b1; nxt = exp_pc + imm; end
            2'd3: begin prd = 1'b1; nxt = ((ins[6:2] == 5'd0) ? 32'h0 : rf[ins[6:2]]) + imm; nxt[0] = 1'b0; end
            default: begin prd = 1'b0; nxt = exp_pc + 32'd4; end
          endcase
          q_instr.push_back(ins); q_pc.push_back(exp_pc); q_pred.push_back(prd);
          exp_pc = nxt;
        end
        live = 0;
      end
      if (hs_ev) begin
        checks++; n_req++;
        if (hs_pc !== exp_pc) begin
          errors++; $display("FAIL rand_req c=%0d: pc=%h, required %h", c, hs_pc, exp_pc);
        end
        live = !fl_ev;
      end
      if (fl_ev) begin
        exp_pc = flush_pc_i;
        q_instr.delete(); q_pc.delete(); q_pred.delete();
        live = 0;
      end
    end
    flush_i = 1'b0;
    checks++;
    if (n_req < 200 || n_ir < 100) begin
      errors++; $display("FAIL rand_progress: requests=%0d ir=%0d, required >=200 >=100", n_req, n_ir);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jalr();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
